// File: rtl/icache_fill_ctrl_if.sv
// Bundles the requester, bus-read and array-write signals of the icache fill controller.
// "master" is the requester/bus side; "slave" is the fill controller itself.
interface icache_fill_ctrl_if #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
);
    localparam int unsigned SETBITS  = $clog2(LINES);
    localparam int unsigned WORDBITS = $clog2(WORDS);
    localparam int unsigned TAGBITS  = 30 - SETBITS - WORDBITS;

    logic                miss;
    logic [31:0]         miss_addr;
    logic                invalidate_all;
    logic [SETBITS-1:0]  lookup_set;
    logic                lookup_valid;
    logic                busy;
    logic                fill_done;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ready;
    logic [31:0]         mem_rdata;
    logic [WORDS-1:0]    wm_we;
    logic [SETBITS-1:0]  wm_set;
    logic [31:0]         wm_wd;
    logic                tag_we;
    logic [TAGBITS-1:0]  tag_wd;

    modport master (
        output miss, miss_addr, invalidate_all, lookup_set, mem_ready, mem_rdata,
        input  lookup_valid, busy, fill_done, mem_req, mem_addr, wm_we, wm_set, wm_wd,
               tag_we, tag_wd
    );

    modport slave (
        input  miss, miss_addr, invalidate_all, lookup_set, mem_ready, mem_rdata,
        output lookup_valid, busy, fill_done, mem_req, mem_addr, wm_we, wm_set, wm_wd,
               tag_we, tag_wd
    );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Instruction-cache line fill controller: reads one block word by word from the bus,
// writes the word memories and tag array, and tracks a valid bit per set.
module icache_fill_ctrl #(
    parameter int unsigned LINES = 16,
    parameter int unsigned WORDS = 4
) (
    input logic               clk,
    input logic               reset,
    icache_fill_ctrl_if.slave bus
);
    localparam int unsigned SETBITS  = $clog2(LINES);
    localparam int unsigned WORDBITS = $clog2(WORDS);
    localparam int unsigned TAGBITS  = 30 - SETBITS - WORDBITS;

    typedef enum logic [1:0] {StIdle, StFill, StDone} state_e;

    state_e               state_q, state_d;
    logic [WORDBITS-1:0]  cnt_q, cnt_d;
    logic [SETBITS-1:0]   set_q, set_d;
    logic [TAGBITS-1:0]   tag_q, tag_d;
    logic [LINES-1:0]     valid_q;

    // Byte and word offsets of the miss address are irrelevant: fills start at word 0.
    logic unused_addr;
    assign unused_addr = ^bus.miss_addr[WORDBITS+1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            set_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            set_q   <= set_d;
            tag_q   <= tag_d;
        end
    end

    // invalidate_all takes priority over the fill completing in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (bus.invalidate_all) begin
            valid_q <= '0;
        end else if (state_q == StDone) begin
            valid_q[set_q] <= 1'b1;
        end
    end

    assign bus.lookup_valid = valid_q[bus.lookup_set];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        set_d         = set_q;
        tag_d         = tag_q;
        bus.busy      = 1'b0;
        bus.fill_done = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_addr  = '0;
        bus.wm_we     = '0;
        bus.wm_set    = '0;
        bus.wm_wd     = '0;
        bus.tag_we    = 1'b0;
        bus.tag_wd    = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.miss) begin
                    set_d   = bus.miss_addr[WORDBITS+2 +: SETBITS];
                    tag_d   = bus.miss_addr[SETBITS+WORDBITS+2 +: TAGBITS];
                    cnt_d   = '0;
                    state_d = StFill;
                end
            end
            StFill: begin
                bus.busy     = 1'b1;
                bus.mem_req  = 1'b1;
                bus.mem_addr = {tag_q, set_q, cnt_q, 2'b00};
                bus.wm_set   = set_q;
                if (bus.mem_ready) begin
                    bus.wm_we = WORDS'(1) << cnt_q;
                    bus.wm_wd = bus.mem_rdata;
                    if (cnt_q == WORDBITS'(WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + WORDBITS'(1);
                    end
                end
            end
            StDone: begin
                bus.busy      = 1'b1;
                bus.fill_done = 1'b1;
                bus.tag_we    = 1'b1;
                bus.tag_wd    = tag_q;
                bus.wm_set    = set_q;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Directed and randomized checks of icache_fill_ctrl against an address-arithmetic model.
module tb_icache_fill_ctrl;
    localparam int unsigned LINES = 16;
    localparam int unsigned WORDS = 4;
    localparam int unsigned SB    = $clog2(LINES);
    localparam int unsigned WB    = $clog2(WORDS);

    logic clk;
    logic reset;

    icache_fill_ctrl_if #(.LINES(LINES), .WORDS(WORDS)) bus ();

    icache_fill_ctrl #(.LINES(LINES), .WORDS(WORDS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit [LINES-1:0] valid_m;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic all_outputs_zero(input string pfx);
        chk({pfx, "_busy"},   64'(bus.busy), 64'(0));
        chk({pfx, "_done"},   64'(bus.fill_done), 64'(0));
        chk({pfx, "_req"},    64'(bus.mem_req), 64'(0));
        chk({pfx, "_addr"},   64'(bus.mem_addr), 64'(0));
        chk({pfx, "_we"},     64'(bus.wm_we), 64'(0));
        chk({pfx, "_set"},    64'(bus.wm_set), 64'(0));
        chk({pfx, "_wd"},     64'(bus.wm_wd), 64'(0));
        chk({pfx, "_tagwe"},  64'(bus.tag_we), 64'(0));
        chk({pfx, "_tagwd"},  64'(bus.tag_wd), 64'(0));
        chk({pfx, "_lookup"}, 64'(bus.lookup_valid), 64'(0));
    endtask

    task automatic check_lookups(input string pfx);
        for (int s = 0; s < LINES; s++) begin
            bus.lookup_set = SB'(s);
            #1;
            chk($sformatf("%s_valid%0d", pfx, s), 64'(bus.lookup_valid), 64'(valid_m[s]));
        end
        @(negedge clk);
    endtask

    // noise: 0 none, 1 miss held with noise_addr, 2 random miss/address/invalidate.
    task automatic run_fill(input logic [31:0] addr, input int stall_word, input int stall_n,
                            input int rand_stall, input int noise, input logic [31:0] noise_addr,
                            input bit inv_accept, input bit inv_done);
        int          set_e;
        logic [31:0] tag_e;
        logic [31:0] base;
        logic [31:0] data;
        int          ns;
        bit          last;
        set_e = int'((addr >> (2 + WB)) % LINES);
        tag_e = addr >> (2 + WB + SB);
        base  = addr & ~(32'(4 * WORDS) - 32'd1);

        bus.miss = 1'b1;
        bus.miss_addr = addr;
        bus.invalidate_all = inv_accept;
        bus.mem_ready = 1'b0;
        #1;
        chk("idle_busy", 64'(bus.busy), 64'(0));
        chk("idle_req", 64'(bus.mem_req), 64'(0));
        tick();
        if (inv_accept) valid_m = '0;
        bus.miss = 1'b0;
        bus.invalidate_all = 1'b0;

        for (int i = 0; i < WORDS; i++) begin
            if (i == stall_word) ns = stall_n;
            else if (rand_stall > 0) ns = int'($urandom_range(rand_stall, 0));
            else ns = 0;
            for (int s = 0; s <= ns; s++) begin
                last = (s == ns);
                data = $urandom;
                bus.mem_ready = last;
                bus.mem_rdata = data;
                if (noise == 1) begin
                    bus.miss = 1'b1;
                    bus.miss_addr = noise_addr;
                end else if (noise == 2) begin
                    bus.miss = 1'($urandom_range(1, 0));
                    bus.miss_addr = $urandom;
                    bus.invalidate_all = ($urandom_range(7, 0) == 0);
                end
                #1;
                chk("fill_req", 64'(bus.mem_req), 64'(1));
                chk("fill_addr", 64'(bus.mem_addr), 64'(base + 32'(4 * i)));
                chk("fill_set", 64'(bus.wm_set), 64'(set_e));
                chk("fill_busy", 64'(bus.busy), 64'(1));
                chk("fill_tagwe", 64'(bus.tag_we), 64'(0));
                chk("fill_done", 64'(bus.fill_done), 64'(0));
                chk("fill_we", 64'(bus.wm_we), last ? (64'(1) << i) : 64'(0));
                if (last) chk("fill_wd", 64'(bus.wm_wd), 64'(data));
                tick();
                if (bus.invalidate_all) valid_m = '0;
            end
        end

        bus.mem_ready = 1'b0;
        bus.invalidate_all = inv_done;
        if (noise == 2) bus.miss = 1'($urandom_range(1, 0));
        #1;
        chk("done_tagwe", 64'(bus.tag_we), 64'(1));
        chk("done_tagwd", 64'(bus.tag_wd), 64'(tag_e));
        chk("done_pulse", 64'(bus.fill_done), 64'(1));
        chk("done_set", 64'(bus.wm_set), 64'(set_e));
        chk("done_busy", 64'(bus.busy), 64'(1));
        chk("done_req", 64'(bus.mem_req), 64'(0));
        chk("done_we", 64'(bus.wm_we), 64'(0));
        tick();
        if (inv_done) valid_m = '0;
        else valid_m[set_e] = 1'b1;
        bus.miss = 1'b0;
        bus.invalidate_all = 1'b0;
        #1;
        chk("post_busy", 64'(bus.busy), 64'(0));
        chk("post_done", 64'(bus.fill_done), 64'(0));
        chk("post_tagwe", 64'(bus.tag_we), 64'(0));
    endtask

    initial begin
        valid_m = '0;
        reset = 1'b0;
        bus.miss = 1'b0;
        bus.miss_addr = '0;
        bus.invalidate_all = 1'b0;
        bus.lookup_set = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        #1;
        all_outputs_zero("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        check_lookups("init");

        // Zero-wait fill of 0x1234: set 3, tag 0x12.
        run_fill(32'h0000_1234, -1, 0, 0, 0, '0, 1'b0, 1'b0);
        bus.lookup_set = SB'(3);
        #1;
        chk("basic_set3", 64'(bus.lookup_valid), 64'(1));
        check_lookups("basic");

        // Three stall cycles before word 2.
        run_fill(32'h0000_1234, 2, 3, 0, 0, '0, 1'b0, 1'b0);

        // Miss to 0x5670 held throughout the fill is ignored.
        valid_m = '0;
        bus.invalidate_all = 1'b1;
        tick();
        bus.invalidate_all = 1'b0;
        run_fill(32'h0000_1234, -1, 0, 0, 1, 32'h0000_5670, 1'b0, 1'b0);
        check_lookups("ignore");

        // invalidate_all in the DONE cycle wins over the fill.
        run_fill(32'h0000_1234, -1, 0, 0, 0, '0, 1'b0, 1'b1);
        check_lookups("invdone");

        // Reset after word 1 is written.
        bus.miss = 1'b1;
        bus.miss_addr = 32'h0000_1234;
        tick();
        bus.miss = 1'b0;
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.mem_rdata = $urandom;
            #1;
            chk("pre_rst_we", 64'(bus.wm_we), 64'(1) << i);
            tick();
        end
        bus.lookup_set = SB'(3);
        reset = 1'b0;
        #1;
        all_outputs_zero("midrst");
        tick();
        reset = 1'b1;
        valid_m = '0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("postrst_we", 64'(bus.wm_we), 64'(0));
            chk("postrst_busy", 64'(bus.busy), 64'(0));
            tick();
        end
        bus.mem_ready = 1'b0;
        check_lookups("midrst");

        // Back-to-back fills of sets 3 and 4; the set-4 miss is held during the first fill.
        run_fill(32'h0000_1234, -1, 0, 0, 1, 32'h0000_1240, 1'b0, 1'b0);
        run_fill(32'h0000_1240, -1, 0, 0, 0, '0, 1'b0, 1'b0);
        check_lookups("b2b");

        // Randomized fills with stalls, ignored misses and invalidations.
        for (int n = 0; n < 24; n++) begin
            run_fill($urandom, -1, 0, 2, 2, '0, ($urandom_range(4, 0) == 0),
                     ($urandom_range(4, 0) == 0));
            check_lookups("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
